// File: rtl/pipe_hazard_ctrl.sv
// Purpose  : stall/flush controller for an N-stage in-order pipeline (stall/bubble decode, flush sequencer, stall watchdog).
// Latency  : stall/bubble/flush decode is combinational (0 cycles); flush lasts FLUSH_CYCLES cycles incl. the request cycle.
// Backpress: i_rdy=0 freezes every stage (all stalls set, no bubbles/flushes); FSM, watchdog and counters hold.
//
// Ports:
//   i_clk, i_rst       clock (rising edge), synchronous active-high reset
//   i_rdy              global ready; 0 freezes the pipeline
//   i_stall_req        per-stage stall requests (0 = fetch, NUM_STAGES-1 = writeback)
//   i_flush_req        single-cycle flush pulse; i_flush_stage=f flushes stages 0..f-1
//   o_stall_out        stage holds its register
//   o_bubble_out       stage loads a NOP
//   o_flush_out        stage invalidates its contents
//   o_flush_busy       flush sequence in progress (FLUSH state)
//   o_stall_timeout    sticky watchdog flag, cleared only by reset
//   o_stall_cycles     stalled-cycle counter (perf)
//   o_flush_count      accepted flush counter (perf)
// Configuration: define PIPE_PERF_CNT_EN to build the perf counters; otherwise they read 0.

module pipe_hazard_ctrl #(
  parameter int NUM_STAGES   = 5,
  parameter int STAGE_W      = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 64,
  parameter int CNT_W        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rdy,
  input  logic [NUM_STAGES-1:0] i_stall_req,
  input  logic                  i_flush_req,
  input  logic [STAGE_W-1:0]    i_flush_stage,
  output logic [NUM_STAGES-1:0] o_stall_out,
  output logic [NUM_STAGES-1:0] o_bubble_out,
  output logic [NUM_STAGES-1:0] o_flush_out,
  output logic                  o_flush_busy,
  output logic                  o_stall_timeout,
  output logic [CNT_W-1:0]      o_stall_cycles,
  output logic [CNT_W-1:0]      o_flush_count
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int SC_W = $clog2(MAX_STALL + 1);
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_MAX    = SC_W'(MAX_STALL);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  // Flush FSM state
  state_t                r_state;
  logic [FC_W-1:0]       r_cnt;
  logic [NUM_STAGES-1:0] r_mask;
  state_t                w_state_nxt;
  logic [FC_W-1:0]       w_cnt_nxt;
  logic [NUM_STAGES-1:0] w_mask_nxt;

  // Watchdog state
  logic [SC_W-1:0]       r_sc;
  logic                  r_timeout;

  // Decode wires
  logic [NUM_STAGES-1:0] w_stall_raw;
  logic [NUM_STAGES-1:0] w_bubble_raw;
  logic [NUM_STAGES-1:0] w_req_bits;
  logic                  w_fl_valid;
  logic                  w_fl_accept;
  logic [NUM_STAGES-1:0] w_flush;
  logic                  w_busy;
  logic [NUM_STAGES-1:0] w_stall_out;
  logic [NUM_STAGES-1:0] w_bubble_out;

  // Stall decode: stage i stalls when any stage at or beyond i requests a
  // stall (all i <= k, k = highest requester). The bubble goes into the
  // stage just past k, i.e. where the stall region ends.
  always_comb begin
    logic acc;
    acc          = 1'b0;
    w_stall_raw  = '0;
    w_bubble_raw = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc            = acc | i_stall_req[i];
      w_stall_raw[i] = acc;
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      w_bubble_raw[i] = w_stall_raw[i-1] & ~w_stall_raw[i];
    end
  end

  // Flush request decode: f selects stages 0..f-1; f=0 or f>=NUM_STAGES is
  // not a legal request and is dropped entirely (not counted either).
  always_comb begin
    w_req_bits = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_req_bits[i] = (i < int'(i_flush_stage));
    end
  end

  assign w_fl_valid  = i_flush_req && (i_flush_stage != '0) &&
                       (int'(i_flush_stage) < NUM_STAGES);
  assign w_fl_accept = w_fl_valid && i_rdy && !i_rst;

  // Flush FSM next state and flush mask output
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;
    w_flush     = '0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fl_accept) begin
          // The request cycle itself is the first flush cycle.
          w_flush = w_req_bits;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = S_FLUSH;
            w_cnt_nxt   = FC_RELOAD;
            w_mask_nxt  = w_req_bits;
          end
        end
      end
      S_FLUSH: begin
        w_busy = 1'b1;
        if (i_rdy) begin
          if (w_fl_accept) begin
            // A new request widens the mask and restarts the length count.
            w_flush    = r_mask | w_req_bits;
            w_mask_nxt = r_mask | w_req_bits;
            w_cnt_nxt  = FC_RELOAD;
          end else begin
            w_flush = r_mask;
            if (r_cnt == FC_W'(1)) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
              w_mask_nxt  = '0;
            end else begin
              w_cnt_nxt = r_cnt - 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_mask_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  // Watchdog: consecutive ready cycles with any stall request. The flag is
  // set on the edge where the count reaches MAX_STALL and is sticky.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sc      <= '0;
      r_timeout <= 1'b0;
    end else if (i_rdy) begin
      if (|i_stall_req) begin
        if (r_sc != SC_MAX) begin
          r_sc <= r_sc + 1'b1;
        end
        if (r_sc >= SC_MAX - 1'b1) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_sc <= '0;
      end
    end
  end

  // Output combine: flush wins over stall/bubble on the same stage; a
  // frozen pipeline holds every stage and suppresses bubbles and flushes.
  always_comb begin
    w_stall_out  = '0;
    w_bubble_out = '0;
    if (i_rst) begin
      w_stall_out  = '0;
      w_bubble_out = '0;
    end else if (!i_rdy) begin
      w_stall_out  = '1;
      w_bubble_out = '0;
    end else begin
      w_stall_out  = w_stall_raw  & ~w_flush;
      w_bubble_out = w_bubble_raw & ~w_flush;
    end
  end

  assign o_stall_out     = w_stall_out;
  assign o_bubble_out    = w_bubble_out;
  assign o_flush_out     = (i_rst || !i_rdy) ? '0 : w_flush;
  assign o_flush_busy    = !i_rst && w_busy;
  assign o_stall_timeout = !i_rst && r_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  // Saturating perf counters; only ready cycles count as stalled cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (i_rdy && (|w_stall_out) && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_fl_accept && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign o_stall_cycles = i_rst ? '0 : r_stall_cycles;
  assign o_flush_count  = i_rst ? '0 : r_flush_count;
`else
  assign o_stall_cycles = '0;
  assign o_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose  : self-checking bench for pipe_hazard_ctrl (N=5, FLUSH_CYCLES=2, MAX_STALL=64).
// Latency  : inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
// Backpress: rdy is driven low in dedicated and random cycles to exercise the freeze behaviour.

module tb_pipe_hazard_ctrl;

  localparam int N   = 5;
  localparam int FC  = 2;
  localparam int MAX = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rdy = 1'b1;
  logic [N-1:0] stall_req = '0;
  logic         flush_req = 1'b0;
  logic [2:0]   flush_stage = '0;

  logic [N-1:0] o_stall_out;
  logic [N-1:0] o_bubble_out;
  logic [N-1:0] o_flush_out;
  logic         o_flush_busy;
  logic         o_stall_timeout;
  logic [31:0]  o_stall_cycles;
  logic [31:0]  o_flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl #(
    .NUM_STAGES  (N),
    .STAGE_W     (3),
    .FLUSH_CYCLES(FC),
    .MAX_STALL   (MAX),
    .CNT_W       (32)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rdy          (rdy),
    .i_stall_req    (stall_req),
    .i_flush_req    (flush_req),
    .i_flush_stage  (flush_stage),
    .o_stall_out    (o_stall_out),
    .o_bubble_out   (o_bubble_out),
    .o_flush_out    (o_flush_out),
    .o_flush_busy   (o_flush_busy),
    .o_stall_timeout(o_stall_timeout),
    .o_stall_cycles (o_stall_cycles),
    .o_flush_count  (o_flush_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Flush tracked as "cycles still to go after this one" plus a stage set.
  logic [N-1:0] m_mask = '0;
  int           m_rem  = 0;
  int           m_sc   = 0;
  bit           m_to   = 1'b0;
  longint       m_cyc  = 0;
  longint       m_fcnt = 0;
  logic [N-1:0] m_new;

  logic [N-1:0] exp_stall, exp_bubble, exp_flush;
  logic         exp_busy, exp_to;
  logic [31:0]  exp_cyc, exp_fc;

  task automatic model_comb();
    int k;
    logic [N-1:0] fl, st, bb;
    k = -1;
    for (int i = 0; i < N; i++) if (stall_req[i]) k = i;
    m_new = '0;
    if (!rst && rdy && flush_req && flush_stage >= 1 && int'(flush_stage) < N)
      for (int i = 0; i < int'(flush_stage); i++) m_new[i] = 1'b1;
    fl = rdy ? (m_mask | m_new) : '0;
    st = '0;
    bb = '0;
    for (int i = 0; i <= k; i++) st[i] = 1'b1;
    if (k >= 0 && k < N - 1) bb[k+1] = 1'b1;
    if (rst) begin
      exp_stall = '0; exp_bubble = '0; exp_flush = '0;
      exp_busy = 1'b0; exp_to = 1'b0; exp_cyc = '0; exp_fc = '0;
    end else begin
      exp_stall  = rdy ? (st & ~fl) : '1;
      exp_bubble = rdy ? (bb & ~fl) : '0;
      exp_flush  = fl;
      exp_busy   = (m_rem > 0);
      exp_to     = m_to;
`ifdef PIPE_PERF_CNT_EN
      exp_cyc = 32'(m_cyc);
      exp_fc  = 32'(m_fcnt);
`else
      exp_cyc = '0;
      exp_fc  = '0;
`endif
    end
  endtask

  task automatic model_seq();
    if (rst) begin
      m_mask = '0; m_rem = 0; m_sc = 0; m_to = 1'b0; m_cyc = 0; m_fcnt = 0;
    end else if (rdy) begin
      if (m_new != '0) begin
        m_mask = m_mask | m_new;
        m_rem  = FC - 1;
        m_fcnt++;
      end else if (m_rem > 0) begin
        m_rem--;
      end
      if (m_rem == 0) m_mask = '0;
      if (stall_req != '0) begin
        if (m_sc < MAX) m_sc++;
        if (m_sc == MAX) m_to = 1'b1;
      end else begin
        m_sc = 0;
      end
      if (exp_stall != '0) m_cyc++;
    end
  endtask

  // Drive one cycle's inputs and settle to the sampling point.
  task automatic set_in(input logic r, input logic y, input logic [N-1:0] sr,
                        input logic fr, input logic [2:0] fs);
    rst = r; rdy = y; stall_req = sr; flush_req = fr; flush_stage = fs;
    model_comb();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_in(1'b1, 1'b1, 5'b11111, 1'b1, 3'd3);
    n_tests++;
    if ({o_stall_out, o_bubble_out, o_flush_out, o_flush_busy, o_stall_timeout} !== '0 ||
        o_stall_cycles !== 32'd0 || o_flush_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got st=%b bb=%b fl=%b busy=%b to=%b cyc=%0d fc=%0d want all 0",
               o_stall_out, o_bubble_out, o_flush_out, o_flush_busy, o_stall_timeout,
               o_stall_cycles, o_flush_count);
    end
    adv();
    set_in(1'b0, 1'b1, '0, 1'b0, '0);
    n_tests++;
    if ({o_stall_out, o_bubble_out, o_flush_out, o_flush_busy, o_stall_timeout} !== '0 ||
        o_stall_cycles !== 32'd0 || o_flush_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_release: got st=%b bb=%b fl=%b busy=%b to=%b want all 0",
               o_stall_out, o_bubble_out, o_flush_out, o_flush_busy, o_stall_timeout);
    end
    adv();
  endtask

  task automatic test_stall_decode();
    set_in(1'b0, 1'b1, 5'b00100, 1'b0, '0);
    n_tests++;
    if (o_stall_out !== 5'b00111 || o_bubble_out !== 5'b01000) begin
      n_fail++;
      $display("FAIL decode_00100: got st=%b bb=%b want st=00111 bb=01000", o_stall_out, o_bubble_out);
    end
    adv();
    set_in(1'b0, 1'b1, 5'b10001, 1'b0, '0);
    n_tests++;
    if (o_stall_out !== 5'b11111 || o_bubble_out !== 5'b00000) begin
      n_fail++;
      $display("FAIL decode_10001: got st=%b bb=%b want st=11111 bb=00000", o_stall_out, o_bubble_out);
    end
    adv();
    for (int i = 0; i < 40; i++) begin
      set_in(1'b0, 1'b1, 5'($urandom), 1'b0, '0);
      n_tests++;
      if (o_stall_out !== exp_stall || o_bubble_out !== exp_bubble) begin
        n_fail++;
        $display("FAIL decode_rand: req=%b got st=%b bb=%b want st=%b bb=%b",
                 stall_req, o_stall_out, o_bubble_out, exp_stall, exp_bubble);
      end
      adv();
    end
  endtask

  task automatic test_rdy_freeze();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 1'b0, 5'($urandom_range(1, 31)), 1'b1, 3'd4);
      n_tests++;
      if (o_stall_out !== 5'b11111 || o_bubble_out !== '0 || o_flush_out !== '0 ||
          o_stall_cycles !== exp_cyc || o_flush_count !== exp_fc) begin
        n_fail++;
        $display("FAIL rdy_freeze: got st=%b bb=%b fl=%b cyc=%0d fc=%0d want st=11111 bb=0 fl=0 cyc=%0d fc=%0d",
                 o_stall_out, o_bubble_out, o_flush_out, o_stall_cycles, o_flush_count, exp_cyc, exp_fc);
      end
      adv();
    end
    // The flush requests issued while frozen must not have started a flush.
    set_in(1'b0, 1'b1, '0, 1'b0, '0);
    n_tests++;
    if (o_flush_out !== '0 || o_flush_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_flush_ignored: got fl=%b busy=%b want fl=0 busy=0", o_flush_out, o_flush_busy);
    end
    adv();
  endtask

  task automatic test_flush();
    set_in(1'b0, 1'b1, '0, 1'b1, 3'd3);
    n_tests++;
    if (o_flush_out !== 5'b00111 || o_flush_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_c0: got fl=%b busy=%b want fl=00111 busy=0", o_flush_out, o_flush_busy);
    end
    adv();
    set_in(1'b0, 1'b1, 5'b01000, 1'b0, '0);
    n_tests++;
    if (o_flush_out !== 5'b00111 || o_flush_busy !== 1'b1 ||
        o_stall_out !== 5'b01000 || o_bubble_out !== 5'b10000) begin
      n_fail++;
      $display("FAIL flush_c1: got fl=%b busy=%b st=%b bb=%b want fl=00111 busy=1 st=01000 bb=10000",
               o_flush_out, o_flush_busy, o_stall_out, o_bubble_out);
    end
    adv();
    set_in(1'b0, 1'b1, '0, 1'b0, '0);
    n_tests++;
    if (o_flush_out !== '0 || o_flush_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done: got fl=%b busy=%b want fl=0 busy=0", o_flush_out, o_flush_busy);
    end
    adv();
    // Flush overriding a stall inside the flushed range.
    set_in(1'b0, 1'b1, 5'b00010, 1'b1, 3'd3);
    n_tests++;
    if (o_flush_out !== 5'b00111 || o_stall_out !== '0 || o_bubble_out !== '0) begin
      n_fail++;
      $display("FAIL flush_over_stall: got fl=%b st=%b bb=%b want fl=00111 st=0 bb=0",
               o_flush_out, o_stall_out, o_bubble_out);
    end
    adv();
    set_in(1'b0, 1'b1, '0, 1'b0, '0);
    adv();
    // Illegal stage selects are dropped.
    for (int fs = 0; fs < 8; fs++) begin
      if (fs >= 1 && fs < N) continue;
      set_in(1'b0, 1'b1, '0, 1'b1, 3'(fs));
      n_tests++;
      if (o_flush_out !== '0) begin
        n_fail++;
        $display("FAIL flush_illegal_f%0d: got fl=%b want 0", fs, o_flush_out);
      end
      adv();
      set_in(1'b0, 1'b1, '0, 1'b0, '0);
      n_tests++;
      if (o_flush_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_illegal_busy_f%0d: got busy=%b want 0", fs, o_flush_busy);
      end
      adv();
    end
  endtask

  task automatic test_flush_extend();
    logic [N-1:0] want [4];
    logic         wbsy [4];
    want = '{5'b00111, 5'b00111, 5'b00111, 5'b00000};
    wbsy = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 4; c++) begin
      if (c == 0)      set_in(1'b0, 1'b1, '0, 1'b1, 3'd3);
      else if (c == 1) set_in(1'b0, 1'b1, '0, 1'b1, 3'd2);
      else             set_in(1'b0, 1'b1, '0, 1'b0, '0);
      n_tests++;
      if (o_flush_out !== want[c] || o_flush_busy !== wbsy[c]) begin
        n_fail++;
        $display("FAIL flush_extend_c%0d: got fl=%b busy=%b want fl=%b busy=%b",
                 c, o_flush_out, o_flush_busy, want[c], wbsy[c]);
      end
      adv();
    end
    // Reset during FLUSH.
    set_in(1'b0, 1'b1, '0, 1'b1, 3'd4);
    adv();
    set_in(1'b1, 1'b1, '0, 1'b0, '0);
    adv();
    set_in(1'b0, 1'b1, '0, 1'b0, '0);
    n_tests++;
    if (o_flush_out !== '0 || o_flush_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_reset: got fl=%b busy=%b want fl=0 busy=0", o_flush_out, o_flush_busy);
    end
    adv();
  endtask

  task automatic test_watchdog();
    int early;
    set_in(1'b1, 1'b1, '0, 1'b0, '0);
    adv();
    early = 0;
    for (int i = 0; i < MAX; i++) begin
      set_in(1'b0, 1'b1, 5'b00100, 1'b0, '0);
      if (o_stall_timeout !== 1'b0) early++;
      adv();
    end
    n_tests++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL watchdog_early: timeout high in %0d of first %0d cycles, want 0", early, MAX);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, '0, 1'b0, '0);
      n_tests++;
      if (o_stall_timeout !== 1'b1) begin
        n_fail++;
        $display("FAIL watchdog_sticky_%0d: got to=%b want 1", i, o_stall_timeout);
      end
      adv();
    end
    set_in(1'b1, 1'b1, '0, 1'b0, '0);
    adv();
    set_in(1'b0, 1'b1, '0, 1'b0, '0);
    n_tests++;
    if (o_stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL watchdog_rst_clear: got to=%b want 0", o_stall_timeout);
    end
    adv();
  endtask

  task automatic test_perf();
    logic [31:0] want_cyc, want_fc;
`ifdef PIPE_PERF_CNT_EN
    want_cyc = 32'd10;
    want_fc  = 32'd3;
`else
    want_cyc = 32'd0;
    want_fc  = 32'd0;
`endif
    set_in(1'b1, 1'b1, '0, 1'b0, '0);
    adv();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 1'b1, 5'b00001, 1'b0, '0);
      adv();
    end
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 1'b0, 5'b00001, 1'b0, '0);
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, '0, 1'b1, 3'd1);
      adv();
      set_in(1'b0, 1'b1, '0, 1'b0, '0);
      adv();
      adv();
    end
    set_in(1'b0, 1'b1, '0, 1'b0, '0);
    n_tests++;
    if (o_stall_cycles !== want_cyc || o_flush_count !== want_fc) begin
      n_fail++;
      $display("FAIL perf_counts: got cyc=%0d fc=%0d want cyc=%0d fc=%0d",
               o_stall_cycles, o_flush_count, want_cyc, want_fc);
    end
    adv();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 59) == 0),
             ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0,
             ($urandom_range(0, 3) == 0),
             3'($urandom));
      n_tests++;
      if ({o_stall_out, o_bubble_out, o_flush_out, o_flush_busy, o_stall_timeout} !==
          {exp_stall, exp_bubble, exp_flush, exp_busy, exp_to} ||
          o_stall_cycles !== exp_cyc || o_flush_count !== exp_fc) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random_%0d: got st=%b bb=%b fl=%b busy=%b to=%b cyc=%0d fc=%0d want st=%b bb=%b fl=%b busy=%b to=%b cyc=%0d fc=%0d",
                   i, o_stall_out, o_bubble_out, o_flush_out, o_flush_busy, o_stall_timeout,
                   o_stall_cycles, o_flush_count, exp_stall, exp_bubble, exp_flush, exp_busy,
                   exp_to, exp_cyc, exp_fc);
        bad++;
      end
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_stall_decode();
    test_rdy_freeze();
    test_flush();
    test_flush_extend();
    test_watchdog();
    test_perf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
